vid_status_leds: RTL and testbench
==================================

// Module: vid_status_leds
// PURPOSE
//  Parametrised status/error LED controller for the video capture designs.
//  Takes N_ERR error pulses from the video pipeline (PHY, sync, render, ...)
//  and a heartbeat qualifier, and drives the 3 PWM inputs of SB_RGBA_DRV.
//  Errors are held on the LED for a full period, never dropped. Sticky flags
//  and saturating event counters are readable over the muacm2wb Wishbone bus.
// PARAMETERS
//  N_ERR   2   number of error channels, 1..4
//  HOLD_W  26  period counter width; display period = 2^HOLD_W clk cycles
//  PWM_W   3   brightness PWM resolution (bits), < HOLD_W
//  CNT_W   8   per-channel event counter width, 1..8
// PORTS
//  clk       in   1      clock; every input is synchronous to it
//  rst_n     in   1      asynchronous, active-low reset
//  err_i     in   N_ERR  error pulses, one per channel, level counted per cycle
//  hb_i      in   1      heartbeat qualifier (e.g. video active)
//  wb_addr   in   2      register select
//  wb_wdata  in   32     write data
//  wb_rdata  out  32     read data, valid only with wb_ack
//  wb_we     in   1      write strobe
//  wb_cyc    in   1      cycle request
//  wb_ack    out  1      cycle acknowledge
//  rgb_pwm   out  3      PWM drive to SB_RGBA_DRV RGB0..2
// BEHAVIOUR
//  Reset: rgb_pwm=0, wb_ack=0, wb_rdata=0, all counters/flags/accumulators 0,
//   ctrl to defaults below.
//  per_cnt: HOLD_W-bit free-running up counter. wrap = (per_cnt == all ones).
//  Display hold, per channel i:
//   acc[i] <= wrap ? 0 : acc[i] | err_i[i].
//   disp[i] <= wrap ? (acc[i] | err_i[i]) : disp[i].
//   An error in period k is shown for all of period k+1, including an error
//   on the wrap cycle itself.
//  sticky[i]: set by err_i[i]; cleared by a reg0 write with wdata[i]=1 (W1C).
//   Set and clear in the same cycle -> set wins.
//  cnt[i]: CNT_W-bit, +1 per cycle with err_i[i]=1, saturates at all ones.
//   A reg2 write clears all counters; clear with err_i[i]=1 in that cycle
//   -> cnt[i]=1.
//  Registers (wb_addr):
//   0 RW1C [N_ERR-1:0] sticky; other bits read 0
//   1 RW   [PWM_W-1:0] duty (reset 1); [7] hb_en (reset 1);
//          [8+3*i+:3] colour mask for channel i (reset ch0=100, ch1=010,
//          ch2/ch3=001); unimplemented bits read 0
//   2 RW   read {cnt[3],..,cnt[0]}, each zero-extended to 8 bits, absent
//          channels read 0; any write clears all counters
//   3 RO   {16'h5354, 8'(N_ERR), 8'(CNT_W)}; writes ignored
//  Wishbone: wb_ack pulses for exactly 1 cycle, the cycle after wb_cyc is
//   first seen high. No ack in the cycle after an ack, so a held wb_cyc gives
//   one ack per 2 cycles. Write side effects happen in the ack cycle.
//   wb_rdata is 0 when wb_ack=0.
//  Output (registered, 1-cycle latency):
//   gate = per_cnt[PWM_W-1:0] < duty; duty 0 -> LEDs off.
//   hb = hb_en & hb_i & per_cnt[HOLD_W-1] (colour 0 only).
//   rgb_pwm[c] <= gate & ((c==0 & hb) | OR_i(disp[i] & mask_i[c])).
//  Reset asserted mid-operation clears everything asynchronously. Any
//   in-flight Wishbone cycle is dropped with no ack.
// TESTING (bench: HOLD_W=6, PWM_W=3, N_ERR=2)
//  1 err_i[0] pulse at per_cnt=10 -> rgb_pwm[2] gated from next wrap for 64
//    cycles, then off; the same pulse on the wrap cycle -> shown next period.
//  2 err_i[1] high 300 cycles, CNT_W=8 -> reg2 reads 0x0000_00FF<<8
//    (saturated); write reg2 while err_i[1]=1 -> reads 0x0000_0100.
//  3 sticky: err_i=2'b11, then write reg0=0x1 -> reads 0x2; W1C coincident
//    with err_i[0] -> bit 0 stays 1.
//  4 duty=0 -> rgb_pwm stays 0; duty=7 -> 7 of every 8 cycles high while disp
//    is set; hb_i=1 with hb_en=1 -> rgb_pwm[0] pulses only when per_cnt[5]=1.
//  5 remap: reg1 mask ch0=001 -> ch0 error drives rgb_pwm[0], not [2];
//    reg3 reads 0x5354_0208.
//  6 rst_n low during ack and while disp is set -> rgb_pwm and wb_ack are 0
//    immediately; registers are back at defaults.

Source files
------------

// File: rtl/vid_status_leds_if.sv
`default_nettype none
// ============================================================================
// Module      : vid_status_leds_if
// Description : Wishbone register-access bundle for the status LED controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface vid_status_leds_if;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport master (
        output wb_addr, wb_wdata, wb_we, wb_cyc,
        input  wb_rdata, wb_ack
    );

    modport slave (
        input  wb_addr, wb_wdata, wb_we, wb_cyc,
        output wb_rdata, wb_ack
    );
endinterface
`default_nettype wire

// File: rtl/vid_status_leds.sv
`default_nettype none
// ============================================================================
// Module      : vid_status_leds
// Description : Error/heartbeat LED controller with held error display, sticky
//               flags and saturating event counters behind a Wishbone port.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_status_leds #(
    parameter int N_ERR  = 2,
    parameter int HOLD_W = 26,
    parameter int PWM_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_ERR-1:0] err_i,
    input  logic             hb_i,
    vid_status_leds_if.slave wb,
    output logic [2:0]       rgb_pwm
);

    function automatic logic [N_ERR-1:0][2:0] mask_reset();
        logic [N_ERR-1:0][2:0] m;
        for (int i = 0; i < N_ERR; i++) begin
            m[i] = (i == 0) ? 3'b100 : ((i == 1) ? 3'b010 : 3'b001);
        end
        return m;
    endfunction

    localparam logic [N_ERR-1:0][2:0] c_mask_rst = mask_reset();
    localparam logic [31:0]           c_id_word  = {16'h5354, 8'(N_ERR), 8'(CNT_W)};

    logic [HOLD_W-1:0]           per_cnt_q, per_cnt_d;
    logic [N_ERR-1:0]            acc_q, acc_d;
    logic [N_ERR-1:0]            disp_q, disp_d;
    logic [N_ERR-1:0]            sticky_q, sticky_d;
    logic [N_ERR-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0]            duty_q, duty_d;
    logic                        hb_en_q, hb_en_d;
    logic [N_ERR-1:0][2:0]       mask_q, mask_d;
    logic                        ack_q, ack_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [2:0]                  rgb_q, rgb_d;

    logic        w_wrap;
    logic        w_wr;
    logic        w_gate;
    logic        w_hb;
    logic [31:0] w_rd;
    logic        w_unused;

    assign w_wrap    = &per_cnt_q;
    assign per_cnt_d = per_cnt_q + HOLD_W'(1);
    // Writes commit on the clock edge that closes the ack cycle.
    assign w_wr      = ack_q & wb.wb_cyc & wb.wb_we;
    assign w_gate    = per_cnt_q[PWM_W-1:0] < duty_q;
    assign w_hb      = hb_en_q & hb_i & per_cnt_q[HOLD_W-1];
    assign ack_d     = wb.wb_cyc & ~ack_q;
    assign rdata_d   = ack_d ? w_rd : 32'd0;
    assign w_unused  = ^wb.wb_wdata;

    always_comb begin
        acc_d    = '0;
        disp_d   = '0;
        sticky_d = '0;
        cnt_d    = '0;
        for (int i = 0; i < N_ERR; i++) begin
            acc_d[i]    = w_wrap ? 1'b0 : (acc_q[i] | err_i[i]);
            disp_d[i]   = w_wrap ? (acc_q[i] | err_i[i]) : disp_q[i];
            sticky_d[i] = err_i[i] |
                          (sticky_q[i] & ~(w_wr && (wb.wb_addr == 2'd0) && wb.wb_wdata[i]));
            cnt_d[i]    = (w_wr && (wb.wb_addr == 2'd2)) ? '0 : cnt_q[i];
            if (err_i[i] && (cnt_d[i] != '1)) begin
                cnt_d[i] = cnt_d[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        duty_d  = duty_q;
        hb_en_d = hb_en_q;
        mask_d  = mask_q;
        if (w_wr && (wb.wb_addr == 2'd1)) begin
            duty_d  = wb.wb_wdata[PWM_W-1:0];
            hb_en_d = wb.wb_wdata[7];
            for (int i = 0; i < N_ERR; i++) begin
                mask_d[i] = wb.wb_wdata[8+3*i +: 3];
            end
        end
    end

    always_comb begin
        w_rd = 32'd0;
        case (wb.wb_addr)
            2'd0: w_rd[N_ERR-1:0] = sticky_q;
            2'd1: begin
                w_rd[PWM_W-1:0] = duty_q;
                w_rd[7]         = hb_en_q;
                for (int i = 0; i < N_ERR; i++) begin
                    w_rd[8+3*i +: 3] = mask_q[i];
                end
            end
            2'd2: begin
                for (int i = 0; i < N_ERR; i++) begin
                    w_rd[8*i +: CNT_W] = cnt_q[i];
                end
            end
            default: w_rd = c_id_word;
        endcase
    end

    // Heartbeat is hard-wired to colour 0; errors route through their masks.
    always_comb begin
        rgb_d = {2'b00, w_hb};
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N_ERR; i++) begin
                rgb_d[c] = rgb_d[c] | (disp_q[i] & mask_q[i][c]);
            end
        end
        if (!w_gate) begin
            rgb_d = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
            acc_q     <= '0;
            disp_q    <= '0;
            sticky_q  <= '0;
            cnt_q     <= '0;
            duty_q    <= PWM_W'(1);
            hb_en_q   <= 1'b1;
            mask_q    <= c_mask_rst;
            ack_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rgb_q     <= 3'b000;
        end else begin
            per_cnt_q <= per_cnt_d;
            acc_q     <= acc_d;
            disp_q    <= disp_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            hb_en_q   <= hb_en_d;
            mask_q    <= mask_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            rgb_q     <= rgb_d;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_rdata = rdata_q;
    assign rgb_pwm     = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_status_leds.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_status_leds
// Description : Self-checking bench for vid_status_leds (HOLD_W=6, N_ERR=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_status_leds;
    localparam int N_ERR  = 2;
    localparam int HOLD_W = 6;
    localparam int PWM_W  = 3;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_ERR-1:0] err_i;
    logic             hb_i;
    logic [2:0]       rgb_pwm;

    vid_status_leds_if bus ();

    vid_status_leds #(
        .N_ERR  (N_ERR),
        .HOLD_W (HOLD_W),
        .PWM_W  (PWM_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .err_i   (err_i),
        .hb_i    (hb_i),
        .wb      (bus.slave),
        .rgb_pwm (rgb_pwm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference state for the LED path; register-side fields follow bench writes.
    logic [HOLD_W-1:0] m_pc;
    logic [N_ERR-1:0]  m_acc, m_disp;
    logic [PWM_W-1:0]  m_duty;
    logic              m_hb_en;
    logic [2:0]        m_mask [N_ERR];
    logic [2:0]        rgb_exp [$];
    logic [31:0]       rd_q [$];

    task automatic model_defaults();
        m_duty    = 3'd1;
        m_hb_en   = 1'b1;
        m_mask[0] = 3'b100;
        m_mask[1] = 3'b010;
    endtask

    always @(posedge clk or negedge rst_n) begin : p_model
        logic [2:0] e;
        if (!rst_n) begin
            m_pc   = '0;
            m_acc  = '0;
            m_disp = '0;
            rgb_exp.delete();
        end else begin
            e = 3'b000;
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < N_ERR; i++)
                    if (m_disp[i] && m_mask[i][c]) e[c] = 1'b1;
            if (m_hb_en && hb_i && m_pc[HOLD_W-1]) e[0] = 1'b1;
            if (m_pc[PWM_W-1:0] >= m_duty) e = 3'b000;
            rgb_exp.push_back(e);
            if (m_pc == 6'd63) begin
                m_disp = m_acc | err_i;
                m_acc  = '0;
            end else begin
                m_acc = m_acc | err_i;
            end
            m_pc = m_pc + 6'd1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rgb_exp.size() > 0)
            check("rgb_pwm", {29'd0, rgb_pwm}, {29'd0, rgb_exp.pop_front()});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [HOLD_W-1:0] v);
        int k = 0;
        while (m_pc != v && k < 200) begin
            tick();
            k++;
        end
        if (m_pc != v) check("wait_pc_timeout", {26'd0, m_pc}, {26'd0, v});
    endtask

    task automatic pulse(input int ch, input logic [HOLD_W-1:0] pc);
        wait_pc(pc);
        err_i[ch] = 1'b1;
        tick();
        err_i[ch] = 1'b0;
    endtask

    task automatic count_hi(input int b, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (b == 3 ? (|rgb_pwm) : rgb_pwm[b]) cnt++;
        end
    endtask

    task automatic wb_xfer(input string tag, input logic we, input logic [1:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
        logic got = 1'b0;
        bus.wb_cyc   = 1'b1;
        bus.wb_we    = we;
        bus.wb_addr  = addr;
        bus.wb_wdata = wdata;
        if (!we) rd_q.push_back(exp_rd);
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            got = bus.wb_ack;
        end
        if (!got) begin
            check({tag, "_ack_timeout"}, {31'd0, got}, 32'd1);
            rd_q.delete();
        end else if (!we) begin
            check(tag, bus.wb_rdata, rd_q.pop_front());
        end
        tick();
        check({tag, "_ack_gap"}, {31'd0, bus.wb_ack}, 32'd0);
        check({tag, "_rdata_idle"}, bus.wb_rdata, 32'd0);
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
        if (we && addr == 2'd1) begin
            m_duty    = wdata[2:0];
            m_hb_en   = wdata[7];
            m_mask[0] = wdata[10:8];
            m_mask[1] = wdata[13:11];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        err_i        = '0;
        hb_i         = 1'b0;
        bus.wb_cyc   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = 2'd0;
        bus.wb_wdata = 32'd0;
        model_defaults();
        rst_n = 1'b0;
        #1;
        check("rst_rgb",   {29'd0, rgb_pwm}, 32'd0);
        check("rst_ack",   {31'd0, bus.wb_ack}, 32'd0);
        check("rst_rdata", bus.wb_rdata, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        wb_xfer("rst_reg0", 1'b0, 2'd0, 32'd0, 32'h0000_0000);
        wb_xfer("rst_reg1", 1'b0, 2'd1, 32'd0, 32'h0000_1481);
        wb_xfer("rst_reg2", 1'b0, 2'd2, 32'd0, 32'h0000_0000);
        wb_xfer("reg3_id",  1'b0, 2'd3, 32'd0, 32'h5354_0208);

        // Error held for the whole following period, mid-period and on the wrap.
        pulse(0, 6'd10);
        wait_pc(6'd0);
        count_hi(2, 64, cnt); check("t1_shown", cnt, 8);
        count_hi(2, 64, cnt); check("t1_cleared", cnt, 0);
        pulse(0, 6'd63);
        count_hi(2, 64, cnt); check("t1_wrap_shown", cnt, 8);
        count_hi(2, 64, cnt); check("t1_wrap_cleared", cnt, 0);

        // Counters: saturation and clear-with-event.
        wb_xfer("t2_two_pulses", 1'b0, 2'd2, 32'd0, 32'h0000_0002);
        wb_xfer("t2_clear_wr",   1'b1, 2'd2, 32'd0, 32'd0);
        wb_xfer("t2_cleared",    1'b0, 2'd2, 32'd0, 32'h0000_0000);
        err_i[1] = 1'b1;
        repeat (300) tick();
        err_i[1] = 1'b0;
        wb_xfer("t2_saturated",  1'b0, 2'd2, 32'd0, 32'h0000_FF00);
        err_i[1] = 1'b1;
        wb_xfer("t2_clr_err_wr", 1'b1, 2'd2, 32'd0, 32'd0);
        err_i[1] = 1'b0;
        wb_xfer("t2_clr_err",    1'b0, 2'd2, 32'd0, 32'h0000_0100);

        // Sticky W1C and set-wins.
        err_i = 2'b11;
        tick();
        err_i = 2'b00;
        wb_xfer("t3_both",      1'b0, 2'd0, 32'd0, 32'h0000_0003);
        wb_xfer("t3_w1c_wr",    1'b1, 2'd0, 32'h1, 32'd0);
        wb_xfer("t3_w1c",       1'b0, 2'd0, 32'd0, 32'h0000_0002);
        err_i[0] = 1'b1;
        wb_xfer("t3_race_wr",   1'b1, 2'd0, 32'h1, 32'd0);
        err_i[0] = 1'b0;
        wb_xfer("t3_set_wins",  1'b0, 2'd0, 32'd0, 32'h0000_0003);
        wb_xfer("t3_clr_wr",    1'b1, 2'd0, 32'h3, 32'd0);
        wb_xfer("t3_clr",       1'b0, 2'd0, 32'd0, 32'h0000_0000);

        // Duty and heartbeat.
        wb_xfer("t4_duty0_wr", 1'b1, 2'd1, 32'h0000_1480, 32'd0);
        pulse(0, 6'd10);
        wait_pc(6'd0);
        count_hi(3, 64, cnt); check("t4_duty0_off", cnt, 0);
        wb_xfer("t4_duty7_wr", 1'b1, 2'd1, 32'h0000_1487, 32'd0);
        pulse(0, 6'd10);
        wait_pc(6'd0);
        count_hi(2, 8, cnt);  check("t4_duty7_first8", cnt, 7);
        count_hi(2, 56, cnt); check("t4_duty7_rest", cnt, 49);
        hb_i = 1'b1;
        count_hi(0, 64, cnt); check("t4_hb_on", cnt, 28);
        wb_xfer("t4_hb_off_wr", 1'b1, 2'd1, 32'h0000_1407, 32'd0);
        wait_pc(6'd0);
        count_hi(0, 64, cnt); check("t4_hb_disabled", cnt, 0);
        hb_i = 1'b0;

        // Colour remap and ID.
        wb_xfer("t5_remap_wr", 1'b1, 2'd1, 32'h0000_1181, 32'd0);
        wb_xfer("t5_remap_rd", 1'b0, 2'd1, 32'd0, 32'h0000_1181);
        pulse(0, 6'd10);
        wait_pc(6'd0);
        count_hi(0, 64, cnt); check("t5_remap_red", cnt, 8);
        wb_xfer("t5_id",       1'b0, 2'd3, 32'd0, 32'h5354_0208);

        // Held cycle: one ack every other cycle.
        bus.wb_cyc  = 1'b1;
        bus.wb_we   = 1'b0;
        bus.wb_addr = 2'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("held_ack",   {31'd0, bus.wb_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("held_rdata", bus.wb_rdata, (k % 2 == 0) ? 32'h5354_0208 : 32'd0);
        end
        bus.wb_cyc = 1'b0;
        tick();

        // Asynchronous reset during an ack with the LED lit.
        wb_xfer("t6_duty7_wr", 1'b1, 2'd1, 32'h0000_1187, 32'd0);
        pulse(0, 6'd10);
        wait_pc(6'd3);
        bus.wb_cyc   = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 2'd1;
        bus.wb_wdata = 32'd0;
        tick();
        check("t6_ack_before", {31'd0, bus.wb_ack}, 32'd1);
        check("t6_rgb_before", {29'd0, rgb_pwm}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rgb_reset",   {29'd0, rgb_pwm}, 32'd0);
        check("t6_ack_reset",   {31'd0, bus.wb_ack}, 32'd0);
        check("t6_rdata_reset", bus.wb_rdata, 32'd0);
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
        model_defaults();
        rd_q.delete();
        tick();
        check("t6_ack_held_rst", {31'd0, bus.wb_ack}, 32'd0);
        #2;
        rst_n = 1'b1;
        wb_xfer("t6_reg1_dflt", 1'b0, 2'd1, 32'd0, 32'h0000_1481);
        wb_xfer("t6_reg0_dflt", 1'b0, 2'd0, 32'd0, 32'h0000_0000);
        wb_xfer("t6_reg2_dflt", 1'b0, 2'd2, 32'd0, 32'h0000_0000);
        count_hi(3, 64, cnt); check("t6_leds_dark", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
